// File: rtl/mux_4x1_rr.sv
// Four-channel merge onto one registered output word with round-robin or fixed-priority
// arbitration, valid/ready on every side, and a channel select for a downstream demux_1x4.
module mux_4x1_rr #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] y,
    output logic             S_0,
    output logic             S_1,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       sel_q, sel_d;
    logic             y_valid_q, y_valid_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             load;
    logic             grant_found;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a new word when empty or being drained this cycle.
    assign load = !y_valid_q || y_ready;

    // Search starts at ptr (round-robin) or at channel a (fixed priority).
    always_comb begin
        grant_found = 1'b0;
        grant       = 2'd0;
        idx         = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = FIXED_PRI ? 2'(k) : ptr_q + 2'(k);
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        grant_data = a;
        unique case (grant)
            2'd0: grant_data = a;
            2'd1: grant_data = b;
            2'd2: grant_data = c;
            2'd3: grant_data = d;
            default: grant_data = a;
        endcase
    end

    always_comb begin
        in_ready = 4'b0000;
        if (!rst && load && grant_found) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        y_d       = y_q;
        sel_d     = sel_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (load) begin
            if (grant_found) begin
                y_d       = grant_data;
                sel_d     = grant;
                y_valid_d = 1'b1;
                ptr_d     = grant + 2'd1;
            end else begin
                // Nothing to send: drop valid but keep the last word and select visible.
                y_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            sel_q     <= 2'd0;
            y_valid_q <= 1'b0;
            ptr_q     <= 2'd0;
        end else begin
            y_q       <= y_d;
            sel_q     <= sel_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign S_0     = sel_q[0];
    assign S_1     = sel_q[1];
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Directed bench for mux_4x1_rr: vector table for the main stream, hand sequences for
// fixed priority, demux loopback and mid-stream reset.
module tb_mux_4x1_rr;

    typedef struct {
        logic [3:0] iv;
        logic       yr;
        logic [7:0] bdat;
        logic [3:0] exp_rdy;
        logic [7:0] exp_y;
        logic [1:0] exp_s;
        logic       exp_v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, c, d;
    logic [3:0] in_valid;
    logic       y_ready;

    logic [3:0] in_ready, f_in_ready;
    logic [7:0] y, f_y;
    logic       S_0, S_1, y_valid;
    logic       f_S_0, f_S_1, f_y_valid;

    int checks = 0;
    int errors = 0;

    vec_t       vecs[19];
    logic [7:0] dmx[4];
    logic [7:0] chan[4];
    int         order[4];

    always #5 clk = ~clk;

    mux_4x1_rr #(.WIDTH(8), .FIXED_PRI(1'b0)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .S_0(S_0), .S_1(S_1), .y_valid(y_valid), .y_ready(y_ready)
    );

    mux_4x1_rr #(.WIDTH(8), .FIXED_PRI(1'b1)) dut_fix (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_ready(f_in_ready),
        .y(f_y), .S_0(f_S_0), .S_1(f_S_1), .y_valid(f_y_valid), .y_ready(y_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] iv, input logic yr, input logic [7:0] bdat,
                                input logic [3:0] rdy, input logic [7:0] ey,
                                input logic [1:0] es, input logic ev);
        vec_t v;
        v.iv = iv; v.yr = yr; v.bdat = bdat; v.exp_rdy = rdy;
        v.exp_y = ey; v.exp_s = es; v.exp_v = ev;
        return v;
    endfunction

    initial begin
        // Round-robin stream, 8 words from ptr=a.
        vecs[0]  = mk(4'b1111, 1'b1, 8'h22, 4'b0001, 8'h11, 2'd0, 1'b1);
        vecs[1]  = mk(4'b1111, 1'b1, 8'h22, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[2]  = mk(4'b1111, 1'b1, 8'h22, 4'b0100, 8'h33, 2'd2, 1'b1);
        vecs[3]  = mk(4'b1111, 1'b1, 8'h22, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[4]  = mk(4'b1111, 1'b1, 8'h22, 4'b0001, 8'h11, 2'd0, 1'b1);
        vecs[5]  = mk(4'b1111, 1'b1, 8'h22, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[6]  = mk(4'b1111, 1'b1, 8'h22, 4'b0100, 8'h33, 2'd2, 1'b1);
        vecs[7]  = mk(4'b1111, 1'b1, 8'h22, 4'b1000, 8'h44, 2'd3, 1'b1);
        // Sparse b/d.
        vecs[8]  = mk(4'b1010, 1'b1, 8'h22, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[9]  = mk(4'b1010, 1'b1, 8'h22, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[10] = mk(4'b1010, 1'b1, 8'h22, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[11] = mk(4'b1010, 1'b1, 8'h22, 4'b1000, 8'h44, 2'd3, 1'b1);
        // Backpressure on b.
        vecs[12] = mk(4'b0010, 1'b1, 8'hB5, 4'b0010, 8'hB5, 2'd1, 1'b1);
        vecs[13] = mk(4'b0010, 1'b0, 8'hB6, 4'b0000, 8'hB5, 2'd1, 1'b1);
        vecs[14] = mk(4'b0010, 1'b0, 8'hB6, 4'b0000, 8'hB5, 2'd1, 1'b1);
        vecs[15] = mk(4'b0010, 1'b0, 8'hB6, 4'b0000, 8'hB5, 2'd1, 1'b1);
        vecs[16] = mk(4'b0010, 1'b1, 8'hB6, 4'b0010, 8'hB6, 2'd1, 1'b1);
        // Idle: valid drops, word/select hold, pointer stays at c.
        vecs[17] = mk(4'b0000, 1'b1, 8'hB6, 4'b0000, 8'hB6, 2'd1, 1'b0);
        vecs[18] = mk(4'b1111, 1'b1, 8'h22, 4'b0100, 8'h33, 2'd2, 1'b1);

        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        rst = 1'b1; in_valid = 4'b1111; y_ready = 1'b1;
        step();
        step();
        check("reset_y", 32'(y), 32'h0);
        check("reset_s", 32'({S_1, S_0}), 32'h0);
        check("reset_valid", 32'(y_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("first_grant_a", 32'(in_ready), 32'b0001);

        for (int i = 0; i < 19; i++) begin
            in_valid = vecs[i].iv;
            y_ready  = vecs[i].yr;
            b        = vecs[i].bdat;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            step();
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_s", i), 32'({S_1, S_0}), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_valid", i), 32'(y_valid), 32'(vecs[i].exp_v));
        end

        // Fixed priority: a always wins. Main instance pointer moves 3,0,1,2 -> back to d.
        b = 8'h22; in_valid = 4'b1111; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fix_in_ready", 32'(f_in_ready), 32'b0001);
            step();
            check("fix_y", 32'(f_y), 32'h11);
            check("fix_s", 32'({f_S_1, f_S_0}), 32'h0);
            check("fix_valid", 32'(f_y_valid), 32'h1);
        end

        // Loopback through a demux model; pointer sits at d.
        chan[0] = 8'hA1; chan[1] = 8'hB2; chan[2] = 8'hC3; chan[3] = 8'hD4;
        a = chan[0]; b = chan[1]; c = chan[2]; d = chan[3];
        order[0] = 3; order[1] = 0; order[2] = 1; order[3] = 2;
        for (int i = 0; i < 4; i++) dmx[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (y_valid && y_ready) dmx[{S_1, S_0}] = y;
            check("loop_sel", 32'({S_1, S_0}), 32'(order[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("loop_demux_out%0d", i), 32'(dmx[i]), 32'(chan[i]));
        end

        // Reset mid-stream: pointer would otherwise be at d.
        rst = 1'b1;
        step();
        check("midrst_valid", 32'(y_valid), 32'h0);
        check("midrst_y", 32'(y), 32'h0);
        rst = 1'b0;
        #1;
        check("midrst_grant_a", 32'(in_ready), 32'b0001);
        step();
        check("midrst_y_a", 32'(y), 32'hA1);
        check("midrst_s_a", 32'({S_1, S_0}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
